// File: rtl/fetch_stage.sv
// Instruction fetch stage: in-order imem request/response handling, 2-entry decode buffer and field split.
// Optional opcode legality check is compiled in when FETCH_ILLEGAL_CHECK_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        illegal_instr
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 2;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q    [2];
    logic [XLEN-1:0] pc_d    [2];
    logic [XLEN-1:0] instr_q [2];
    logic [XLEN-1:0] instr_d [2];
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   outst_left;
    logic [CW:0]     occ;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] head_instr;
    logic            rsp, pop_raw, pop, xfer, keep_c, discard_c, wr_idx;

    // Handshake terms; a response with nothing outstanding is stray and ignored.
    assign id_valid   = !rst && (count_q != '0);
    assign pop_raw    = id_valid && id_ready;
    assign pop        = pop_raw && !flush;
    assign occ        = {1'b0, count_q} + {1'b0, outst_q} - (CW+1)'(pop_raw);
    assign imem_req   = !rst && !flush && (occ < (CW+1)'(2));
    assign imem_addr  = fetch_pc_q;
    assign xfer       = imem_req && imem_gnt;
    assign rsp        = imem_rvalid && (outst_q != '0);
    assign outst_left = outst_q - CW'(rsp);
    // Kept requests are contiguous and end at fetch_pc-4, so the oldest one sits outstanding*4 back.
    assign rsp_pc     = fetch_pc_q - XLEN'({outst_q, 2'b00});
    assign wr_idx     = count_q[0] ^ pop;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = (outst_left != '0) ? DRAIN : RUN;
        end else if (state_q == DRAIN && rsp && drop_q == CW'(1)) begin
            state_d = RUN;
        end
    end

    always_comb begin
        keep_c    = 1'b0;
        discard_c = 1'b0;
        case (state_q)
            RUN:     keep_c    = rsp && !flush;
            DRAIN:   discard_c = rsp;
            default: ;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        outst_d    = outst_q + CW'(xfer) - CW'(rsp);
        drop_d     = drop_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        if (flush) begin
            fetch_pc_d = flush_target;
            count_d    = '0;
            drop_d     = outst_left;
        end else begin
            if (xfer) fetch_pc_d = fetch_pc_q + XLEN'(4);
            count_d = count_q + CW'(keep_c) - CW'(pop);
            if (discard_c) drop_d = drop_q - CW'(1);
            if (pop) begin
                pc_d[0]    = pc_q[1];
                instr_d[0] = instr_q[1];
            end
            if (keep_c) begin
                pc_d[wr_idx]    = rsp_pc;
                instr_d[wr_idx] = imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            pc_q       <= '{default: '0};
            instr_q    <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

    assign head_instr = id_valid ? instr_q[0] : '0;
    assign id_pc      = id_valid ? pc_q[0] : '0;
    assign {funct7, rs2, rs1, funct3, rd, opcode} = head_instr;

`ifdef FETCH_ILLEGAL_CHECK_EN
    logic opcode_ok;
    always_comb begin
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: opcode_ok = 1'b1;
            default:                                        opcode_ok = 1'b0;
        endcase
    end
    assign illegal_instr = id_valid && !opcode_ok;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model with variable latency, expected
// {pc, instr} queued at each granted request and compared as the decode side consumes them.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_gnt, imem_rvalid, flush, id_ready, id_valid, illegal_instr;
    logic [31:0] imem_addr, imem_rdata, flush_target, id_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          cyc = 0, last_due = 0, n_chk = 0, n_pass = 0, pops = 0;
    int          lat_min = 1, lat_max = 1;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] ff_pc = '0;
    bit          stray = 1'b0, ff_pending = 1'b0, prev_flush = 1'b0;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .flush(flush), .flush_target(flush_target),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        if (obs === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, req, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h200) return 32'h4000_0033;
        if (a == 32'h204) return 32'h0010_0093;
        if (a == 32'h208) return 32'h0000_007f;
        if (a < 32'h100)  return 32'h0000_0033;
        return {a[24:0] ^ {18'b0, a[31:25]}, 7'b0110011};
    endfunction

    function automatic logic exp_illegal(input logic [31:0] w);
        logic legal;
        case (w[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return ILL_EN && !legal;
    endfunction

    // One clock cycle: drive at negedge, let comb settle, then account for what the posedge will do.
    task automatic step(input logic r_i, input logic rdy_i, input logic g_i,
                        input logic f_i, input logic [31:0] tgt_i);
        exp_t h;
        int   due;
        @(negedge clk);
        rst = r_i; id_ready = rdy_i; imem_gnt = g_i; flush = f_i; flush_target = tgt_i;
        imem_rvalid = 1'b0; imem_rdata = '0;
        if (r_i) begin
            mem_addr_q.delete(); mem_due_q.delete(); last_due = cyc;
        end else if (stray) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef; stray = 1'b0;
        end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr_q[0]);
            void'(mem_addr_q.pop_front()); void'(mem_due_q.pop_front());
        end
        #1;
        if (r_i) begin
            check("rst_req",   64'(imem_req), 64'd0);
            check("rst_valid", 64'(id_valid), 64'd0);
            check("rst_pc",    64'(id_pc),    64'd0);
            check("rst_fld",   64'({funct7, rs2, rs1, funct3, rd, opcode, illegal_instr}), 64'd0);
            exp_pc = RST_PC; sb_q.delete(); ff_pending = 1'b0;
        end else begin
            if (prev_flush) check("flush_empty", 64'(id_valid), 64'd0);
            if (id_valid) begin
                if (sb_q.size() == 0) begin
                    check("stale_instr", 64'(id_valid), 64'd0);
                end else begin
                    h = sb_q[0];
                    check("id_pc",     64'(id_pc), 64'(h.pc));
                    check("id_fields", 64'({funct7, rs2, rs1, funct3, rd, opcode}), 64'(h.instr));
                    check("illegal",   64'(illegal_instr), 64'(exp_illegal(h.instr)));
                    if (ff_pending) begin
                        check("flush_pc", 64'(id_pc), 64'(ff_pc));
                        ff_pending = 1'b0;
                    end
                    if (h.pc == 32'h200) begin
                        check("sub_f7", 64'(funct7), 64'(7'b0100000));
                        check("sub_f3", 64'(funct3), 64'd0);
                    end
                    if (h.pc == 32'h204) begin
                        check("addi_op",  64'(opcode), 64'(7'b0010011));
                        check("addi_rd",  64'(rd),     64'd1);
                        check("addi_rs1", 64'(rs1),    64'd0);
                    end
                    if (h.pc == 32'h208) check("illegal_7f", 64'(illegal_instr), 64'(ILL_EN));
                    if (rdy_i && !f_i) begin
                        void'(sb_q.pop_front());
                        pops++;
                    end
                end
            end else begin
                check("empty_pc",  64'(id_pc), 64'd0);
                check("empty_fld", 64'({funct7, rs2, rs1, funct3, rd, opcode, illegal_instr}), 64'd0);
            end
            if (f_i) begin
                check("flush_req", 64'(imem_req), 64'd0);
                sb_q.delete();
                exp_pc = tgt_i; ff_pc = tgt_i; ff_pending = 1'b1;
            end else if (imem_req) begin
                check("imem_addr", 64'(imem_addr), 64'(exp_pc));
                if (g_i) begin
                    sb_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
                    due = cyc + lat_min + int'($urandom_range(0, lat_max - lat_min));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_addr_q.push_back(imem_addr);
                    mem_due_q.push_back(due);
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        prev_flush = f_i && !r_i;
        cyc++;
    endtask

    initial begin
        int budget;
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        flush = 1'b0; flush_target = '0; id_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Streaming with a 1-cycle memory: one request and one instruction per cycle.
        pops = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            check("sustain_req", 64'(imem_req), 64'd1);
            if (i == 1) check("lat_before", 64'(id_valid), 64'd0);
            if (i == 2) check("lat_first",  64'(id_valid), 64'd1);
        end
        check("throughput", 64'(pops), 64'd23);

        // Decode stall: buffer fills, requests stop, nothing lost afterwards.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_req",  64'(imem_req), 64'd0);
        check("stall_full", 64'(id_valid), 64'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Flush with two requests in flight and no response in the flush cycle.
        lat_min = 3; lat_max = 3;
        budget = 0;
        while (!(mem_addr_q.size() == 2 && mem_due_q[0] > cyc) && budget < 30) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            budget++;
        end
        check("drain_setup", 64'(mem_addr_q.size()), 64'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Flush in steady streaming, coinciding with a response and a pop.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Random grant, ready, latency and redirects.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++)
            step(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 3, 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Reset mid-flight, then a stray response that must be ignored.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        stray = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("stray_ignored", 64'(id_valid), 64'd0);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
